// File: rtl/ifft8_seq_core.sv
// Sequential 8-point inverse FFT: serial bit-reversed load, 12 time-shared radix-2 DIT
// butterflies with conjugate twiddles and 1/2 scaling per stage, then serial natural-order unload.
module ifft8_seq_core #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**N-1:0]   in_r,
    input  logic [2**N-1:0]   in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_r,
    output logic [2**N-1:0]   out_i,
    output logic              out_last
);
    localparam int W  = 2**N;
    localparam int WI = W + 2;
    localparam int WP = WI + 10;

    localparam logic signed [WI-1:0] SAT_MAX     = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [WI-1:0] SAT_MIN     = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [WP-1:0] K_INV_SQRT2 = WP'(181);

    typedef enum logic [1:0] {
        S_LOAD,
        S_CALC,
        S_UNLOAD
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_inc;
    logic [3:0]     r_step;
    logic           r_out_valid;
    logic [W-1:0]   r_out_r;
    logic [W-1:0]   r_out_i;
    logic [W-1:0]   r_mem_r [8];
    logic [W-1:0]   r_mem_i [8];

    logic [2:0]     w_a_idx;
    logic [2:0]     w_b_idx;
    logic [1:0]     w_tw;

    logic signed [WI-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [WI-1:0] w_sum, w_dif;
    logic signed [WI-1:0] w_tr, w_ti;
    logic signed [WI-1:0] w_top_r, w_top_i, w_bot_r, w_bot_i;
    logic signed [WP-1:0] w_sum_x, w_dif_x;
    logic signed [WP-1:0] w_ps, w_pd, w_pn;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [WI-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return x[W-1:0];
    endfunction

    assign w_cnt_inc = r_cnt + 3'd1;

    // Butterfly addressing: the stage bit of the top index is 0, the remaining bits come from
    // the step counter so tops ascend; the twiddle code indexes W^-k in eighths of a turn /2.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_a_idx = '0;
        w_b_idx = '0;
        w_tw    = '0;
        case (r_step[3:2])
            2'd0: begin
                w_a_idx = {r_step[1:0], 1'b0};
                w_b_idx = {r_step[1:0], 1'b1};
            end
            2'd1: begin
                w_a_idx = {r_step[1], 1'b0, r_step[0]};
                w_b_idx = {r_step[1], 1'b1, r_step[0]};
                w_tw    = {r_step[0], 1'b0};
            end
            default: begin
                w_a_idx = {1'b0, r_step[1:0]};
                w_b_idx = {1'b1, r_step[1:0]};
                w_tw    = r_step[1:0];
            end
        endcase
    end

    assign w_ar = {{2{r_mem_r[w_a_idx][W-1]}}, r_mem_r[w_a_idx]};
    assign w_ai = {{2{r_mem_i[w_a_idx][W-1]}}, r_mem_i[w_a_idx]};
    assign w_br = {{2{r_mem_r[w_b_idx][W-1]}}, r_mem_r[w_b_idx]};
    assign w_bi = {{2{r_mem_i[w_b_idx][W-1]}}, r_mem_i[w_b_idx]};

    assign w_sum   = w_br + w_bi;
    assign w_dif   = w_br - w_bi;
    assign w_sum_x = {{(WP-WI){w_sum[WI-1]}}, w_sum};
    assign w_dif_x = {{(WP-WI){w_dif[WI-1]}}, w_dif};
    assign w_ps    = w_sum_x * K_INV_SQRT2;
    assign w_pd    = w_dif_x * K_INV_SQRT2;
    assign w_pn    = -w_ps;

    always_comb begin
        w_tr = w_br;
        w_ti = w_bi;
        case (w_tw)
            2'd1: begin
                w_tr = WI'(w_pd >>> 8);
                w_ti = WI'(w_ps >>> 8);
            end
            2'd2: begin
                w_tr = -w_bi;
                w_ti = w_br;
            end
            2'd3: begin
                w_tr = WI'(w_pn >>> 8);
                w_ti = WI'(w_pd >>> 8);
            end
            default: ;
        endcase
    end

    assign w_top_r = (w_ar + w_tr) >>> 1;
    assign w_top_i = (w_ai + w_ti) >>> 1;
    assign w_bot_r = (w_ar - w_tr) >>> 1;
    assign w_bot_i = (w_ai - w_ti) >>> 1;

    // NOTE: the sample memory has no reset; every entry is rewritten by LOAD before it is read.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid) begin
            r_mem_r[bitrev3(r_cnt)] <= in_r;
            r_mem_i[bitrev3(r_cnt)] <= in_i;
        end else if (r_state == S_CALC) begin
            r_mem_r[w_a_idx] <= sat(w_top_r);
            r_mem_i[w_a_idx] <= sat(w_top_i);
            r_mem_r[w_b_idx] <= sat(w_bot_r);
            r_mem_i[w_b_idx] <= sat(w_bot_i);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && r_cnt == 3'd7) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_step == 4'd11) begin
                    w_state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (r_out_valid && out_ready && r_cnt == 3'd7) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // The output register is primed from mem[0] on the first UNLOAD cycle, then refilled on
    // every accepted beat so the presented sample holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_CALC: begin
                    r_step <= (r_step == 4'd11) ? 4'd0 : r_step + 4'd1;
                end
                S_UNLOAD: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_r     <= r_mem_r[r_cnt];
                        r_out_i     <= r_mem_i[r_cnt];
                    end else if (out_ready) begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == 3'd7) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_r <= r_mem_r[w_cnt_inc];
                            r_out_i <= r_mem_i[w_cnt_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_last  = r_out_valid && (r_cnt == 3'd7);

endmodule

// File: tb/tb_ifft8_seq_core.sv
// Scoreboard bench for ifft8_seq_core: directed frames push expected samples into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_ifft8_seq_core;
    localparam int N = 4;
    localparam int W = 2**N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;
    logic         out_last;

    ifft8_seq_core #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int i;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   edge_cyc = 0;
    int   frame_id = 0;
    bit   bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_frame(input int er[8], input int ei[8]);
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            e.r    = er[n];
            e.i    = ei[n];
            e.last = (n == 7);
            exp_q.push_back(e);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that accepted X[7].
    task automatic send_frame(input int xr[8], input int xi[8], input bit gaps);
        for (int k = 0; k < 8; k++) begin
            bit acc;
            int waitc;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_r     = W'(xr[k]);
            in_i     = W'(xi[k]);
            acc      = 1'b0;
            waitc    = 0;
            while (!acc && waitc < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                waitc++;
            end
            if (!acc) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        edge_cyc = cyc;
        frame_id++;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 400) begin
            @(posedge clk);
            waitc++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int pat_idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (pat_idx == 0 || pat_idx == 3);
                pat_idx   = (pat_idx + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    bit       was_stall = 1'b0;
    bit       ready_chk = 1'b0;
    int       lat_done_id = 0;
    logic [W-1:0] held_r, held_i;
    exp_t     mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            was_stall = 1'b0;
            ready_chk = 1'b0;
        end else begin
            if (ready_chk) begin
                check("in_ready_after_last", int'(in_ready), 1);
                ready_chk = 1'b0;
            end
            if (was_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_r", int'($signed(out_r)), int'($signed(held_r)));
                check("stall_i", int'($signed(out_i)), int'($signed(held_i)));
                was_stall = 1'b0;
            end
            if (out_valid) begin
                check("in_ready_low", int'(in_ready), 0);
                if (lat_done_id != frame_id) begin
                    check("latency", cyc - edge_cyc, 13);
                    lat_done_id = frame_id;
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_r", int'($signed(out_r)), mon_e.r);
                        check("out_i", int'($signed(out_i)), mon_e.i);
                        check("out_last", int'(out_last), int'(mon_e.last));
                        if (mon_e.last) ready_chk = 1'b1;
                    end
                end else begin
                    was_stall = 1'b1;
                    held_r    = out_r;
                    held_i    = out_i;
                end
            end
        end
    end

    initial begin
        int xr[8], xi[8], er[8], ei[8];
        int tone_r[8], tone_i[8];

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_i", int'(out_i), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse
        xr = '{800, 0, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        er = '{100, 100, 100, 100, 100, 100, 100, 100};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_frame(er, ei);
        send_frame(xr, xi, 1'b0);
        wait_drain();

        // DC
        xr = '{80, 80, 80, 80, 80, 80, 80, 80};
        er = '{80, 0, 0, 0, 0, 0, 0, 0};
        push_frame(er, ei);
        send_frame(xr, xi, 1'b0);
        wait_drain();

        // Single tone at bin 1
        xr     = '{0, 512, 0, 0, 0, 0, 0, 0};
        tone_r = '{64, 45, 0, -46, -64, -45, 0, 45};
        tone_i = '{0, 45, 64, 45, 0, -45, -64, -45};
        push_frame(tone_r, tone_i);
        send_frame(xr, xi, 1'b0);
        wait_drain();

        // Tone again with input gaps, output backpressure and ignored in_valid while busy
        bp_mode = 1'b1;
        push_frame(tone_r, tone_i);
        send_frame(xr, xi, 1'b1);
        in_valid = 1'b1;
        in_r     = W'(9999);
        in_i     = W'(-1234);
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain();
        bp_mode = 1'b0;

        // Full-scale DC in both components
        xr = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        xi = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        er = '{32767, 0, 0, 0, 0, 0, 0, 0};
        ei = '{32767, 0, 0, 0, 0, 0, 0, 0};
        push_frame(er, ei);
        send_frame(xr, xi, 1'b0);
        wait_drain();

        // Abort a frame during stage 1, then an impulse frame must come out clean
        xr = '{0, 512, 0, 0, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(xr, xi, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_last", int'(out_last), 0);
        check("abort_out_r", int'(out_r), 0);
        check("abort_out_i", int'(out_i), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xr = '{800, 0, 0, 0, 0, 0, 0, 0};
        er = '{100, 100, 100, 100, 100, 100, 100, 100};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_frame(er, ei);
        send_frame(xr, xi, 1'b0);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
